// File: rtl/pdp8_io.sv
// PDP-8 I/O hub: decodes the IOT device field, dispatches to the console
// teletype and the IDE-backed RF08 disk, and merges their replies onto the CPU bus.

module pdp8_tt (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [7:0]  tx_char,
  output logic [11:0] data,
  output logic        data_avail,
  output logic        skip,
  output logic        clear_ac,
  output logic        interrupt
);
  localparam logic [7:0] TX_CYCLES = 8'd40;

  logic        iot_q;
  logic [3:0]  state_q;
  logic [11:0] mb_q;
  logic        go;
  logic        kbd_sel;
  logic        tto_sel;
  logic        kbd_flag;
  logic        tto_flag;
  logic        tto_busy;
  logic [7:0]  kbd_buf;
  logic [7:0]  tto_buf;
  logic [7:0]  tto_cnt;

  assign kbd_sel = iot && (mb[8:3] == 6'o03);
  assign tto_sel = iot && (mb[8:3] == 6'o04);
  // An IOT acts once: when iot rises, or when a new word/major state arrives with iot held
  assign go = iot && (!iot_q || (mb != mb_q) || (state != state_q));
  assign interrupt = kbd_flag | tto_flag;

  always_comb begin
    data       = 12'o0000;
    data_avail = 1'b0;
    skip       = 1'b0;
    clear_ac   = 1'b0;
    if (kbd_sel) begin
      skip       = mb[0] & kbd_flag;
      clear_ac   = mb[1];
      data_avail = mb[2];
      data       = mb[2] ? {4'b0000, kbd_buf} : 12'o0000;
    end else if (tto_sel) begin
      skip = mb[0] & tto_flag;
    end
  end

  // No serial pins reach the hub, so a finished transmit loops back as a received key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iot_q    <= 1'b0;
      state_q  <= 4'd0;
      mb_q     <= 12'o0000;
      kbd_flag <= 1'b0;
      tto_flag <= 1'b0;
      tto_busy <= 1'b0;
      kbd_buf  <= 8'd0;
      tto_buf  <= 8'd0;
      tto_cnt  <= 8'd0;
    end else begin
      iot_q   <= iot;
      state_q <= state;
      mb_q    <= mb;
      if (tto_busy) begin
        if (tto_cnt == 8'd0) begin
          tto_busy <= 1'b0;
          tto_flag <= 1'b1;
          kbd_buf  <= tto_buf;
          kbd_flag <= 1'b1;
        end else begin
          tto_cnt <= tto_cnt - 8'd1;
        end
      end
      if (go && kbd_sel && mb[1]) kbd_flag <= 1'b0;
      if (go && tto_sel && mb[1]) tto_flag <= 1'b0;
      if (go && tto_sel && mb[2]) begin
        tto_buf  <= tx_char;
        tto_cnt  <= TX_CYCLES;
        tto_busy <= 1'b1;
      end
    end
  end
endmodule

module pdp8_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [11:0] io_data_in,
  output logic [11:0] data,
  output logic        data_avail,
  output logic        skip,
  output logic        clear_ac,
  output logic        interrupt,
  output logic        ram_read_req,
  output logic        ram_write_req,
  input  logic        ram_done,
  output logic [14:0] ram_ma,
  input  logic [11:0] ram_in,
  output logic [11:0] ram_out,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da,
  inout  wire  [15:0] ide_data_bus
);
  typedef enum logic [2:0] {
    DMA_IDLE, DMA_IDE_RD, DMA_MEM_WR, DMA_MEM_RD, DMA_IDE_WR
  } dma_state_t;

  dma_state_t  dma_state;
  logic        iot_q;
  logic [3:0]  state_q;
  logic [11:0] mb_q;
  logic        go;
  logic        sel60, sel61, sel62, sel64;
  logic        done_flag, err_flag, int_en;
  logic [2:0]  ema;
  logic [11:0] wc, ca, disk_addr, word;
  logic [11:0] wc_next;
  logic [11:0] status;
  logic [1:0]  strobe_cnt;
  logic        ide_drive;

  assign sel60   = iot && (mb[8:3] == 6'o60);
  assign sel61   = iot && (mb[8:3] == 6'o61);
  assign sel62   = iot && (mb[8:3] == 6'o62);
  assign sel64   = iot && (mb[8:3] == 6'o64);
  assign go      = iot && (!iot_q || (mb != mb_q) || (state != state_q));
  assign wc_next = wc + 12'd1;
  assign status  = {ema, 6'd0, int_en, err_flag, done_flag};

  assign interrupt    = int_en & (done_flag | err_flag);
  assign ram_ma       = {ema, ca};
  assign ram_out      = word;
  assign ide_da       = 3'd0;
  assign ide_data_bus = ide_drive ? {4'b0000, word} : 16'hzzzz;

  always_comb begin
    data       = 12'o0000;
    data_avail = 1'b0;
    skip       = 1'b0;
    clear_ac   = 1'b0;
    if (sel60) begin
      clear_ac = mb[1] | mb[2];
    end else if (sel61) begin
      clear_ac   = mb[1];
      data_avail = mb[1] & mb[2];
      data       = (mb[1] & mb[2]) ? status : 12'o0000;
    end else if (sel62) begin
      skip = (mb[0] & err_flag) | (mb[1] & done_flag);
    end else if (sel64) begin
      clear_ac   = mb[2];
      data_avail = mb[2];
      data       = mb[2] ? disk_addr : 12'o0000;
    end
  end

  // WC counts up from a negative word count; the transfer ends when it wraps to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iot_q         <= 1'b0;
      state_q       <= 4'd0;
      mb_q          <= 12'o0000;
      dma_state     <= DMA_IDLE;
      strobe_cnt    <= 2'd0;
      ram_read_req  <= 1'b0;
      ram_write_req <= 1'b0;
      ide_dior      <= 1'b1;
      ide_diow      <= 1'b1;
      ide_cs        <= 2'b11;
      ide_drive     <= 1'b0;
      done_flag     <= 1'b0;
      err_flag      <= 1'b0;
      int_en        <= 1'b0;
      ema           <= 3'd0;
      wc            <= 12'o0000;
      ca            <= 12'o0000;
      disk_addr     <= 12'o0000;
      word          <= 12'o0000;
    end else begin
      iot_q   <= iot;
      state_q <= state;
      mb_q    <= mb;
      case (dma_state)
        DMA_IDE_RD: begin
          if (strobe_cnt == 2'd3) begin
            word          <= ide_data_bus[11:0];
            if (|ide_data_bus[15:12]) err_flag <= 1'b1;
            ide_dior      <= 1'b1;
            ram_write_req <= 1'b1;
            dma_state     <= DMA_MEM_WR;
          end else begin
            strobe_cnt <= strobe_cnt + 2'd1;
          end
        end
        DMA_MEM_WR: begin
          if (ram_done) begin
            ram_write_req <= 1'b0;
            wc            <= wc_next;
            ca            <= ca + 12'd1;
            disk_addr     <= disk_addr + 12'd1;
            if (wc_next == 12'o0000) begin
              done_flag <= 1'b1;
              ide_cs    <= 2'b11;
              dma_state <= DMA_IDLE;
            end else begin
              ide_dior   <= 1'b0;
              strobe_cnt <= 2'd0;
              dma_state  <= DMA_IDE_RD;
            end
          end
        end
        DMA_MEM_RD: begin
          if (ram_done) begin
            ram_read_req <= 1'b0;
            word         <= ram_in;
            ide_diow     <= 1'b0;
            ide_drive    <= 1'b1;
            ide_cs       <= 2'b10;
            strobe_cnt   <= 2'd0;
            dma_state    <= DMA_IDE_WR;
          end
        end
        DMA_IDE_WR: begin
          if (strobe_cnt == 2'd3) begin
            ide_diow  <= 1'b1;
            ide_drive <= 1'b0;
            ide_cs    <= 2'b11;
            wc        <= wc_next;
            ca        <= ca + 12'd1;
            disk_addr <= disk_addr + 12'd1;
            if (wc_next == 12'o0000) begin
              done_flag <= 1'b1;
              dma_state <= DMA_IDLE;
            end else begin
              ram_read_req <= 1'b1;
              dma_state    <= DMA_MEM_RD;
            end
          end else begin
            strobe_cnt <= strobe_cnt + 2'd1;
          end
        end
        default: ;
      endcase

      if (go && sel60) begin
        if (mb[0]) begin
          done_flag <= 1'b0;
          err_flag  <= 1'b0;
          disk_addr <= 12'o0000;
        end
        if (mb[1] | mb[2]) begin
          if (dma_state != DMA_IDLE) begin
            err_flag <= 1'b1;
          end else begin
            disk_addr <= io_data_in;
            done_flag <= 1'b0;
            if (mb[1]) begin
              ide_dior   <= 1'b0;
              ide_cs     <= 2'b10;
              strobe_cnt <= 2'd0;
              dma_state  <= DMA_IDE_RD;
            end else begin
              ram_read_req <= 1'b1;
              dma_state    <= DMA_MEM_RD;
            end
          end
        end
      end
      if (go && sel61) begin
        if (mb[0] && mb[2]) begin
          ema    <= io_data_in[5:3];
          int_en <= io_data_in[0];
        end else if (mb[0]) begin
          ema    <= 3'd0;
          int_en <= 1'b0;
        end
      end
      if (go && sel64) begin
        if (mb[0]) wc <= io_data_in;
        if (mb[1]) ca <= io_data_in;
      end
    end
  end
endmodule

module pdp8_io (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic [5:0]  io_select,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  output logic        io_clear_ac,
  output logic        io_ram_read_req,
  output logic        io_ram_write_req,
  input  logic        io_ram_done,
  output logic [14:0] io_ram_ma,
  input  logic [11:0] io_ram_in,
  output logic [11:0] io_ram_out,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da,
  inout  wire  [15:0] ide_data_bus
);
  logic [11:0] tt_data, rf_data;
  logic        tt_avail, tt_skip, tt_clear_ac, tt_int;
  logic        rf_avail, rf_skip, rf_clear_ac, rf_int;
  logic        tt_sel, rf_sel;

  assign io_select    = mb[8:3];
  assign tt_sel       = iot && (io_select inside {6'o03, 6'o04});
  assign rf_sel       = iot && (io_select inside {6'o60, 6'o61, 6'o62, 6'o64});
  assign io_interrupt = tt_int | rf_int;

  // Unknown device codes fall through to all-zero replies, so the CPU sees a NOP
  always_comb begin
    io_data_out   = 12'o0000;
    io_data_avail = 1'b0;
    io_skip       = 1'b0;
    io_clear_ac   = 1'b0;
    if (tt_sel) begin
      io_data_out   = tt_data;
      io_data_avail = tt_avail;
      io_skip       = tt_skip;
      io_clear_ac   = tt_clear_ac;
    end else if (rf_sel) begin
      io_data_out   = rf_data;
      io_data_avail = rf_avail;
      io_skip       = rf_skip;
      io_clear_ac   = rf_clear_ac;
    end
  end

  pdp8_tt u_tt (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .tx_char(io_data_in[7:0]),
    .data(tt_data), .data_avail(tt_avail), .skip(tt_skip),
    .clear_ac(tt_clear_ac), .interrupt(tt_int)
  );

  pdp8_rf u_rf (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .io_data_in(io_data_in),
    .data(rf_data), .data_avail(rf_avail), .skip(rf_skip),
    .clear_ac(rf_clear_ac), .interrupt(rf_int),
    .ram_read_req(io_ram_read_req), .ram_write_req(io_ram_write_req),
    .ram_done(io_ram_done), .ram_ma(io_ram_ma), .ram_in(io_ram_in),
    .ram_out(io_ram_out),
    .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs),
    .ide_da(ide_da), .ide_data_bus(ide_data_bus)
  );
endmodule

// File: tb/tb_pdp8_io.sv
// Directed bench for pdp8_io: a vector table for single IOT replies plus
// hand-written sequences for teletype transmit, RF08 DMA and reset abort.

module tb_pdp8_io;
  logic        clk = 1'b0;
  logic        reset;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [11:0] io_data_in;
  logic [11:0] io_data_out;
  logic [5:0]  io_select;
  logic        io_data_avail, io_interrupt, io_skip, io_clear_ac;
  logic        io_ram_read_req, io_ram_write_req, io_ram_done;
  logic [14:0] io_ram_ma;
  logic [11:0] io_ram_in, io_ram_out;
  logic        ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  wire  [15:0] ide_data_bus;
  logic [15:0] ide_rd_value;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int activity = 0;
  int n;

  typedef struct {
    logic        iot;
    logic [11:0] mb;
    logic [11:0] ac;
    logic [5:0]  sel;
    logic [11:0] data;
    logic        avail;
    logic        skip;
    logic        clr;
    logic        intr;
  } vec_t;
  vec_t vecs[15];

  always #5 clk = ~clk;

  // The drive answers data-register reads with whatever the bench has staged
  assign ide_data_bus = ide_dior ? 16'hzzzz : ide_rd_value;

  pdp8_io dut (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .io_data_in(io_data_in), .io_data_out(io_data_out), .io_select(io_select),
    .io_data_avail(io_data_avail), .io_interrupt(io_interrupt),
    .io_skip(io_skip), .io_clear_ac(io_clear_ac),
    .io_ram_read_req(io_ram_read_req), .io_ram_write_req(io_ram_write_req),
    .io_ram_done(io_ram_done), .io_ram_ma(io_ram_ma), .io_ram_in(io_ram_in),
    .io_ram_out(io_ram_out), .ide_dior(ide_dior), .ide_diow(ide_diow),
    .ide_cs(ide_cs), .ide_da(ide_da), .ide_data_bus(ide_data_bus)
  );

  always @(negedge clk) begin
    if (io_ram_read_req && io_ram_write_req) overlap++;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0o, expected %0o", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic i, input logic [11:0] m,
                               input logic [11:0] a);
    @(negedge clk);
    iot = i;
    mb = m;
    io_data_in = a;
    #2;
  endtask

  task automatic endIot();
    @(negedge clk);
    iot = 1'b0;
  endtask

  task automatic doIot(input logic [11:0] m, input logic [11:0] a);
    applyStimulus(1'b1, m, a);
    endIot();
  endtask

  task automatic pulseDone();
    @(negedge clk);
    io_ram_done = 1'b1;
    @(negedge clk);
    io_ram_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; iot = 1'b0; state = 4'd0; mb = 12'o0000; io_data_in = 12'o0000;
    io_ram_done = 1'b0; io_ram_in = 12'o0000; ide_rd_value = 16'h0000;

    vecs[0]  = '{1'b1, 12'o6101, 12'o0000, 6'o10, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 12'o6036, 12'o0000, 6'o03, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 12'o6031, 12'o0000, 6'o03, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 12'o6036, 12'o0000, 6'o03, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 12'o6616, 12'o0000, 6'o61, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 12'o6622, 12'o0000, 6'o62, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 12'o6041, 12'o0000, 6'o04, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 12'o6615, 12'o0031, 6'o61, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 12'o6616, 12'o0000, 6'o61, 12'o3004, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 12'o6611, 12'o0000, 6'o61, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 12'o6616, 12'o0000, 6'o61, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 12'o6644, 12'o0000, 6'o64, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 12'o6641, 12'o7776, 6'o64, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 12'o6642, 12'o0200, 6'o64, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 12'o6632, 12'o0000, 6'o63, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset pulse, then a long idle with no bus or drive activity allowed
    #30;
    checkOutput("in-reset dior", ide_dior, 1);
    checkOutput("in-reset write_req", io_ram_write_req, 0);
    #20;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (io_ram_read_req || io_ram_write_req || !ide_dior || !ide_diow) activity++;
    end
    checkOutput("idle activity", activity, 0);
    checkOutput("reset data_out", io_data_out, 0);
    checkOutput("reset data_avail", io_data_avail, 0);
    checkOutput("reset skip", io_skip, 0);
    checkOutput("reset clear_ac", io_clear_ac, 0);
    checkOutput("reset interrupt", io_interrupt, 0);
    checkOutput("reset read_req", io_ram_read_req, 0);
    checkOutput("reset write_req", io_ram_write_req, 0);
    checkOutput("reset ram_ma", io_ram_ma, 0);
    checkOutput("reset ram_out", io_ram_out, 0);
    checkOutput("reset dior", ide_dior, 1);
    checkOutput("reset diow", ide_diow, 1);
    checkOutput("reset cs", ide_cs, 2'b11);
    checkOutput("reset da", ide_da, 0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].iot, vecs[i].mb, vecs[i].ac);
      checkOutput($sformatf("v%0d select", i), io_select, vecs[i].sel);
      checkOutput($sformatf("v%0d data", i), io_data_out, vecs[i].data);
      checkOutput($sformatf("v%0d avail", i), io_data_avail, vecs[i].avail);
      checkOutput($sformatf("v%0d skip", i), io_skip, vecs[i].skip);
      checkOutput($sformatf("v%0d clear_ac", i), io_clear_ac, vecs[i].clr);
      checkOutput($sformatf("v%0d interrupt", i), io_interrupt, vecs[i].intr);
      endIot();
    end

    // Teletype: TLS, wait for transmit done, then TSF/KSF/KRB on the looped-back char
    applyStimulus(1'b1, 12'o6046, 12'o0101);
    checkOutput("tls skip", io_skip, 0);
    endIot();
    @(negedge clk);
    checkOutput("tls early interrupt", io_interrupt, 0);
    n = 0;
    while (!io_interrupt && n < 200) begin @(negedge clk); n++; end
    checkOutput("tls done interrupt", io_interrupt, 1);
    applyStimulus(1'b1, 12'o6041, 12'o0000);
    checkOutput("tsf skip", io_skip, 1);
    endIot();
    applyStimulus(1'b1, 12'o6031, 12'o0000);
    checkOutput("ksf loopback skip", io_skip, 1);
    endIot();
    applyStimulus(1'b1, 12'o6036, 12'o0000);
    checkOutput("krb data", io_data_out, 12'o0101);
    checkOutput("krb avail", io_data_avail, 1);
    endIot();
    doIot(12'o6042, 12'o0000);
    applyStimulus(1'b1, 12'o6041, 12'o0000);
    checkOutput("tsf after tcf", io_skip, 0);
    checkOutput("tt interrupt cleared", io_interrupt, 0);
    endIot();

    // DMAR: two words from the drive into memory at 0200 (WC/CA loaded by the table)
    ide_rd_value = 16'h0123;
    applyStimulus(1'b1, 12'o6603, 12'o0017);
    checkOutput("dmar clear_ac", io_clear_ac, 1);
    endIot();
    n = 0;
    while (!io_ram_write_req && n < 50) begin @(negedge clk); n++; end
    checkOutput("dmar w0 write_req", io_ram_write_req, 1);
    checkOutput("dmar w0 ma", io_ram_ma, 15'o00200);
    checkOutput("dmar w0 data", io_ram_out, 12'h123);
    repeat (5) @(negedge clk);
    checkOutput("dmar w0 held", io_ram_write_req, 1);
    @(negedge clk);
    io_ram_done = 1'b1;
    ide_rd_value = 16'h0456;
    @(negedge clk);
    io_ram_done = 1'b0;
    checkOutput("dmar w0 req dropped", io_ram_write_req, 0);
    n = 0;
    while (!io_ram_write_req && n < 50) begin @(negedge clk); n++; end
    checkOutput("dmar w1 write_req", io_ram_write_req, 1);
    checkOutput("dmar w1 ma", io_ram_ma, 15'o00201);
    checkOutput("dmar w1 data", io_ram_out, 12'h456);
    pulseDone();
    repeat (2) @(negedge clk);
    checkOutput("dmar finished write_req", io_ram_write_req, 0);
    checkOutput("dmar cs idle", ide_cs, 2'b11);
    applyStimulus(1'b1, 12'o6622, 12'o0000);
    checkOutput("dfsc after dmar", io_skip, 1);
    endIot();
    applyStimulus(1'b1, 12'o6644, 12'o0000);
    checkOutput("disk addr after dmar", io_data_out, 12'o0021);
    endIot();
    checkOutput("rf int disabled", io_interrupt, 0);
    doIot(12'o6615, 12'o0001);
    @(negedge clk);
    checkOutput("rf int enabled", io_interrupt, 1);
    doIot(12'o6611, 12'o0000);
    @(negedge clk);
    checkOutput("rf int after dcim", io_interrupt, 0);

    // DMAW: one word from memory 0300 out to the drive
    doIot(12'o6641, 12'o7777);
    doIot(12'o6642, 12'o0300);
    doIot(12'o6605, 12'o0040);
    n = 0;
    while (!io_ram_read_req && n < 50) begin @(negedge clk); n++; end
    checkOutput("dmaw read_req", io_ram_read_req, 1);
    checkOutput("dmaw ma", io_ram_ma, 15'o00300);
    @(negedge clk);
    io_ram_done = 1'b1;
    io_ram_in = 12'o1234;
    @(negedge clk);
    io_ram_done = 1'b0;
    n = 0;
    while (ide_diow && n < 50) begin @(negedge clk); n++; end
    checkOutput("dmaw diow strobe", ide_diow, 0);
    checkOutput("dmaw ide data", ide_data_bus, 16'h029c);
    repeat (8) @(negedge clk);
    applyStimulus(1'b1, 12'o6622, 12'o0000);
    checkOutput("dfsc after dmaw", io_skip, 1);
    endIot();
    applyStimulus(1'b1, 12'o6644, 12'o0000);
    checkOutput("disk addr after dmaw", io_data_out, 12'o0041);
    endIot();

    // Reset in the middle of a DMAR write request
    doIot(12'o6641, 12'o7776);
    doIot(12'o6642, 12'o0400);
    doIot(12'o6603, 12'o0000);
    n = 0;
    while (!io_ram_write_req && n < 50) begin @(negedge clk); n++; end
    checkOutput("abort pre write_req", io_ram_write_req, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort write_req", io_ram_write_req, 0);
    checkOutput("abort read_req", io_ram_read_req, 0);
    checkOutput("abort dior", ide_dior, 1);
    checkOutput("abort ma", io_ram_ma, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 12'o6616, 12'o0000);
    checkOutput("abort status", io_data_out, 12'o0000);
    endIot();
    applyStimulus(1'b1, 12'o6622, 12'o0000);
    checkOutput("abort dfsc", io_skip, 0);
    endIot();
    repeat (10) @(negedge clk);
    checkOutput("abort stays idle", io_ram_write_req, 0);

    checkOutput("read/write overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
